reg_bank_pn: RTL and testbench
==============================

// Module: reg_bank_pn
// PURPOSE
//  Parametrised successor of the 8x8 load-immediate register bank: Count registers of Width bits.
//  Adds an addressed instruction format and arithmetic ops (INC/DEC/MOV).
//  Adds a multi-cycle clear-all sweep with a ready handshake and a bad-instruction strobe.
//  Sits behind the instruction decoder; out feeds datapath consumers as a flat bus.
// PARAMETERS
//  Width  8  bits per register (>=2)
//  Count  8  number of registers (>=1; need not be a power of 2)
//  AddrW  = (Count>1 ? $clog2(Count) : 1), derived localparam, register address width
//  InstW  = 4+AddrW+Width, derived localparam, instruction width
// PORTS
//  clock     in   1              rising-edge clock
//  reset     in   1              asynchronous, active-low reset (reset==0 resets)
//  inst      in   InstW          {op[3:0], addr[AddrW-1:0], imm[Width-1:0]}
//  inst_en   in   1              instruction valid
//  inst_rdy  out  1              bank can accept; instruction taken when inst_en&&inst_rdy at edge
//  inst_err  out  1              one-cycle pulse: accepted instruction was invalid
//  out       out  Count*Width    register r on out[r*Width +: Width]
// BEHAVIOUR
//  - Reset (async, reset==0): all registers 0, state IDLE, inst_rdy=1, inst_err=0, sweep ptr 0.
//  - Registered: effect visible on out one edge after acceptance. No combinational inst->out path.
//  - Ops: 0 NOP; 1 LDI r<=imm; 2 INC r<=r+1; 3 DEC r<=r-1; 4 MOV r<=reg[imm[AddrW-1:0]];
//    5 CLRA clear all; 6..15 invalid.
//  - Arithmetic mod 2^Width: INC of all-ones gives 0; DEC of 0 gives all-ones.
//  - MOV with src==dst: no change. MOV with src>=Count: invalid.
//  - Invalid op, addr>=Count (r-type ops), or bad MOV src: no register write.
//    inst_err=1 for exactly the following cycle.
//  - inst_err=0 for every valid op and for any cycle with nothing accepted.
//  - addr is ignored for NOP and CLRA; these are never flagged for addr.
//  - State machine IDLE/SWEEP:
//    * IDLE: inst_rdy=1.
//    * CLRA accepted: reg0<=0, ptr<=1. Next state SWEEP if Count>1, else IDLE.
//    * SWEEP: inst_rdy=0. Each edge clears reg[ptr] and increments ptr.
//      On the edge clearing reg[Count-1]: return to IDLE.
//    * CLRA therefore occupies Count cycles; inst_rdy is low for Count-1 cycles.
//  - inst_en while inst_rdy=0: ignored silently, no err. The source must hold the instruction
//    until accepted.
//  - Registers not yet swept keep their values until cleared; out is observable mid-sweep.
//  - Reset mid-sweep: immediate abort; everything returns to reset values.
//  - X on inst while inst_en=0 must not propagate to state or out.
// CONFIGURATION
//  REG_BANK_PN_SATURATE_EN defined:
//    - INC of all-ones holds all-ones; DEC of 0 holds 0.
//    - Each saturating op still counts as valid (inst_err=0).
//  REG_BANK_PN_SATURATE_EN undefined: wrap-around as stated in BEHAVIOUR.
// TESTING (Width=8, Count=8 unless noted)
//  1 Reset low at t=1, release; LDI r0..r7 with BA,FE,23,43,12,EA,FE,AB -> out per reg.
//    Between reset and the first load, out==0, inst_rdy=1.
//  2 LDI r3=FF; INC r3 -> r3=00 (SAT: FF). LDI r4=00; DEC r4 -> r4=FF (SAT: 00).
//    MOV r5<-r0 -> r5=BA.
//  3 inst_en=0 with LDI r1=87 -> r1 unchanged. op=F, imm=AB -> no write, inst_err high 1 cycle.
//    MOV src=3 bits valid, then Count=6 bench: LDI addr=7 -> inst_err, no write.
//  4 CLRA with all regs nonzero -> inst_rdy low 7 cycles; r0..r7 zero in order, one per edge.
//    LDI r1=27 offered during the sweep is accepted only after inst_rdy rises -> r1=27.
//  5 Start CLRA; assert reset low on sweep cycle 3 -> all out=0, inst_rdy=1 immediately.
//    After release, LDI r0=1A -> r0=1A.
//  6 Count=1 bench: CLRA -> inst_rdy never drops, r0=0 next edge. INC/DEC wrap checks pass.

Source files
------------

// File: rtl/reg_bank_pn.sv
// Parametrised register bank: Count x Width registers written by an addressed instruction stream,
// with INC/DEC/MOV, a multi-cycle clear-all sweep and a bad-instruction strobe. Option: REG_BANK_PN_SATURATE_EN.
module reg_bank_pn #(
   parameter int Width = 8,
   parameter int Count = 8,
   localparam int AddrW = (Count > 1) ? $clog2(Count) : 1,
   localparam int InstW = 4 + AddrW + Width
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [InstW-1:0]       inst,
   input  logic                   inst_en,
   output logic                   inst_rdy,
   output logic                   inst_err,
   output logic [Count*Width-1:0] out
);

   // state    | meaning
   // ST_IDLE  | accepting instructions, inst_rdy high
   // ST_SWEEP | clearing reg[ptr] one per edge after CLRA, inst_rdy low
   typedef enum logic {ST_IDLE, ST_SWEEP} state_t;

   localparam logic [AddrW:0]   COUNT_W = (AddrW+1)'(Count);
   localparam logic [AddrW-1:0] LAST    = AddrW'(Count-1);
`ifdef REG_BANK_PN_SATURATE_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   state_t             state_q, state_d;
   logic [AddrW-1:0]   ptr_q, ptr_d;
   logic               err_q, err_d;
   logic [Width-1:0]   regs_q [Count];
   logic [Width-1:0]   regs_d [Count];

   logic [3:0]         op;
   logic [AddrW-1:0]   addr, src;
   logic [Width-1:0]   imm, cur, src_val, wr_val;
   logic               addr_ok, src_ok, wr_en;

   assign op   = inst[InstW-1 -: 4];
   assign addr = inst[Width +: AddrW];
   assign imm  = inst[Width-1:0];

   // MOV source is the low AddrW bits of imm; zero-extend when imm is the narrower field
   generate
      if (AddrW <= Width) begin : g_src_slice
         assign src = imm[AddrW-1:0];
      end else begin : g_src_ext
         assign src = {{(AddrW-Width){1'b0}}, imm};
      end
   endgenerate

   always_comb begin
      cur     = '0;
      src_val = '0;
      for (int i = 0; i < Count; i++) begin
         if (AddrW'(i) == addr) cur = regs_q[i];
         if (AddrW'(i) == src)  src_val = regs_q[i];
      end
      addr_ok = {1'b0, addr} < COUNT_W;
      src_ok  = {1'b0, src}  < COUNT_W;
   end

   always_comb begin
      regs_d  = regs_q;
      state_d = state_q;
      ptr_d   = ptr_q;
      err_d   = 1'b0;
      wr_en   = 1'b0;
      wr_val  = imm;
      case (state_q)
         ST_IDLE: begin
            if (inst_en) begin
               case (op)
                  4'd0: ;
                  4'd1: begin
                     wr_en  = addr_ok;
                     err_d  = !addr_ok;
                  end
                  4'd2: begin
                     wr_en  = addr_ok;
                     err_d  = !addr_ok;
                     wr_val = (SAT && (&cur)) ? cur : cur + Width'(1);
                  end
                  4'd3: begin
                     wr_en  = addr_ok;
                     err_d  = !addr_ok;
                     wr_val = (SAT && (cur == '0)) ? cur : cur - Width'(1);
                  end
                  4'd4: begin
                     wr_en  = addr_ok && src_ok;
                     err_d  = !(addr_ok && src_ok);
                     wr_val = src_val;
                  end
                  4'd5: begin
                     regs_d[0] = '0;
                     ptr_d     = (Count > 1) ? AddrW'(1) : '0;
                     state_d   = (Count > 1) ? ST_SWEEP : ST_IDLE;
                  end
                  default: err_d = 1'b1;
               endcase
            end
         end
         ST_SWEEP: begin
            for (int i = 0; i < Count; i++) begin
               if (AddrW'(i) == ptr_q) regs_d[i] = '0;
            end
            ptr_d = ptr_q + AddrW'(1);
            if (ptr_q == LAST) begin
               state_d = ST_IDLE;
               ptr_d   = '0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      for (int i = 0; i < Count; i++) begin
         if (wr_en && (AddrW'(i) == addr)) regs_d[i] = wr_val;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         err_q   <= 1'b0;
         for (int i = 0; i < Count; i++) regs_q[i] <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         err_q   <= err_d;
         for (int i = 0; i < Count; i++) regs_q[i] <= regs_d[i];
      end
   end

   assign inst_rdy = (state_q == ST_IDLE);
   assign inst_err = err_q;

   always_comb begin
      out = '0;
      for (int i = 0; i < Count; i++) out[i*Width +: Width] = regs_q[i];
   end

endmodule

// File: tb/tb_reg_bank_pn.sv
// Bench for reg_bank_pn: three instances (Count 8, 6, 1; Width 8) driven one at a time against
// an array-based reference model of the instruction set. Honours REG_BANK_PN_SATURATE_EN.
module tb_reg_bank_pn;

`ifdef REG_BANK_PN_SATURATE_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [3:0]  op_i;
   logic [2:0]  addr_i;
   logic [7:0]  imm_i;
   logic        en8 = 1'b0, en6 = 1'b0, en1 = 1'b0;
   logic        rdy8, rdy6, rdy1, err8, err6, err1;
   logic [63:0] out8;
   logic [47:0] out6;
   logic [7:0]  out1;
   logic [14:0] inst8;
   logic [12:0] inst1;

   always #5 clk = ~clk;

   assign inst8 = {op_i, addr_i, imm_i};
   assign inst1 = {op_i, addr_i[0], imm_i};

   reg_bank_pn #(.Width(8), .Count(8)) u_dut8 (
      .clock(clk), .reset(rst_n), .inst(inst8), .inst_en(en8),
      .inst_rdy(rdy8), .inst_err(err8), .out(out8));
   reg_bank_pn #(.Width(8), .Count(6)) u_dut6 (
      .clock(clk), .reset(rst_n), .inst(inst8), .inst_en(en6),
      .inst_rdy(rdy6), .inst_err(err6), .out(out6));
   reg_bank_pn #(.Width(8), .Count(1)) u_dut1 (
      .clock(clk), .reset(rst_n), .inst(inst1), .inst_en(en1),
      .inst_rdy(rdy1), .inst_err(err1), .out(out1));

   int tests = 0;
   int fails = 0;
   int sel = 0;
   int cnt = 8;
   int m [8];

   function automatic logic [7:0] get_out(input int r);
      case (sel)
         0:       return out8[r*8 +: 8];
         1:       return out6[r*8 +: 8];
         default: return out1;
      endcase
   endfunction

   function automatic logic get_rdy();
      case (sel)
         0:       return rdy8;
         1:       return rdy6;
         default: return rdy1;
      endcase
   endfunction

   function automatic logic get_err();
      case (sel)
         0:       return err8;
         1:       return err6;
         default: return err1;
      endcase
   endfunction

   task automatic set_en(input logic v);
      en8 = v && (sel == 0);
      en6 = v && (sel == 1);
      en1 = v && (sel == 2);
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_outs(input string tag);
      for (int r = 0; r < cnt; r++) check($sformatf("%s_r%0d", tag, r), get_out(r), 8'(m[r]));
   endtask

   task automatic check_ctl(input string tag, input logic er, input logic ee);
      check({tag, "_rdy"}, {7'd0, get_rdy()}, {7'd0, er});
      check({tag, "_err"}, {7'd0, get_err()}, {7'd0, ee});
   endtask

   // Idle cycles with X on the instruction bus: nothing may change.
   task automatic idle(input int n);
      op_i = 'x; addr_i = 'x; imm_i = 'x; set_en(1'b0);
      repeat (n) begin
         @(posedge clk);
         @(negedge clk);
         check_outs("idle");
         check_ctl("idle", 1'b1, 1'b0);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      set_en(1'b0);
      rst_n = 1'b0;
      for (int r = 0; r < 8; r++) m[r] = 0;
      #1;
      check_outs("rst");
      check_ctl("rst", 1'b1, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Issue one instruction from a negedge with the bank idle; model it and check the result.
   task automatic exec(input int op, input int addr, input int imm);
      int aw, a, s;
      bit e, clr;
      aw = 1;
      while ((1 << aw) < cnt) aw++;
      a = addr & ((1 << aw) - 1);
      s = imm & ((1 << aw) - 1);
      e = 0; clr = 0;
      op_i = 4'(op); addr_i = 3'(addr); imm_i = 8'(imm);
      set_en(1'b1);
      check("rdy_pre", {7'd0, get_rdy()}, 8'd1);
      @(posedge clk);
      case (op)
         0: ;
         1: if (a < cnt) m[a] = imm; else e = 1;
         2: if (a < cnt) m[a] = (SAT && m[a] == 255) ? 255 : (m[a] + 1) % 256; else e = 1;
         3: if (a < cnt) m[a] = (SAT && m[a] == 0) ? 0 : (m[a] + 255) % 256; else e = 1;
         4: if (a < cnt && s < cnt) m[a] = m[s]; else e = 1;
         5: begin m[0] = 0; clr = 1; end
         default: e = 1;
      endcase
      @(negedge clk);
      set_en(1'b0);
      op_i = 'x; addr_i = 'x; imm_i = 'x;
      check("err", {7'd0, get_err()}, {7'd0, e});
      check_outs($sformatf("op%0d", op));
      if (clr) begin
         for (int k = 1; k < cnt; k++) begin
            check("sweep_rdy", {7'd0, get_rdy()}, 8'd0);
            @(posedge clk);
            m[k] = 0;
            @(negedge clk);
            check_outs("sweep");
            check("sweep_err", {7'd0, get_err()}, 8'd0);
         end
         check("sweep_done_rdy", {7'd0, get_rdy()}, 8'd1);
      end
   endtask

   task automatic rand_run(input int n);
      int op;
      for (int i = 0; i < n; i++) begin
         op = ($urandom_range(0, 9) < 9) ? $urandom_range(0, 7) : $urandom_range(8, 15);
         exec(op, $urandom_range(0, 7), $urandom_range(0, 255));
         if ($urandom_range(0, 3) == 0) idle(1);
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      op_i = 'x; addr_i = 'x; imm_i = 'x;
      for (int r = 0; r < 8; r++) m[r] = 0;
      // reset low at t=1
      #1 rst_n = 1'b0;
      #1;
      check_outs("por");
      check_ctl("por", 1'b1, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      idle(2);

      // load r0..r7
      begin
         logic [7:0] vals [8];
         vals = '{8'hBA, 8'hFE, 8'h23, 8'h43, 8'h12, 8'hEA, 8'hFE, 8'hAB};
         for (int r = 0; r < 8; r++) exec(1, r, vals[r]);
      end
      check("ld_r2", get_out(2), 8'h23);

      // wrap / saturate edges and MOV
      exec(1, 3, 'hFF);
      exec(2, 3, 0);
      check("inc_ff", get_out(3), SAT ? 8'hFF : 8'h00);
      exec(1, 4, 'h00);
      exec(3, 4, 0);
      check("dec_00", get_out(4), SAT ? 8'h00 : 8'hFF);
      exec(4, 5, 0);
      check("mov_r5", get_out(5), 8'hBA);
      exec(4, 2, 2);

      // inst_en low: ignored
      op_i = 4'd1; addr_i = 3'd1; imm_i = 8'h87; set_en(1'b0);
      @(posedge clk);
      @(negedge clk);
      check_outs("noen");
      check("noen_err", {7'd0, get_err()}, 8'd0);

      // invalid op then err drops
      exec(15, 2, 'hAB);
      idle(1);
      // MOV uses only imm[2:0] as source
      exec(4, 6, 'h0B);

      // clear-all with an LDI held during the sweep
      for (int r = 0; r < 8; r++) exec(1, r, $urandom_range(1, 255));
      op_i = 4'd5; addr_i = 3'd0; imm_i = 8'd0; set_en(1'b1);
      @(posedge clk);
      m[0] = 0;
      @(negedge clk);
      op_i = 4'd1; addr_i = 3'd1; imm_i = 8'h27;
      check_outs("clra0");
      for (int k = 1; k < 8; k++) begin
         check("clra_rdy", {7'd0, get_rdy()}, 8'd0);
         @(posedge clk);
         m[k] = 0;
         @(negedge clk);
         check_outs("clra");
         check("clra_err", {7'd0, get_err()}, 8'd0);
      end
      check("clra_rdy_up", {7'd0, get_rdy()}, 8'd1);
      check("r1_not_yet", get_out(1), 8'h00);
      @(posedge clk);
      m[1] = 'h27;
      @(negedge clk);
      set_en(1'b0);
      check("r1_27", get_out(1), 8'h27);
      check_outs("post_clra");
      check_ctl("post_clra", 1'b1, 1'b0);

      // reset in the middle of a sweep
      for (int r = 0; r < 8; r++) exec(1, r, $urandom_range(1, 255));
      op_i = 4'd5; addr_i = 3'd0; imm_i = 8'd0; set_en(1'b1);
      @(posedge clk);
      m[0] = 0;
      @(negedge clk);
      set_en(1'b0);
      for (int k = 1; k < 3; k++) begin
         @(posedge clk);
         m[k] = 0;
         @(negedge clk);
      end
      check_outs("pre_abort");
      rst_n = 1'b0;
      for (int r = 0; r < 8; r++) m[r] = 0;
      #1;
      check_outs("abort");
      check_ctl("abort", 1'b1, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      exec(1, 0, 'h1A);
      check("r0_1a", get_out(0), 8'h1A);

      rand_run(250);

      // Count=6 instance
      sel = 1; cnt = 6;
      do_reset();
      exec(1, 5, 'h11);
      exec(1, 7, 'h22);
      exec(2, 6, 0);
      exec(4, 0, 6);
      exec(4, 0, 5);
      check("c6_mov", get_out(0), 8'h11);
      exec(5, 3, 0);
      rand_run(120);

      // Count=1 instance
      sel = 2; cnt = 1;
      do_reset();
      exec(1, 0, 'h55);
      exec(5, 1, 0);
      check("c1_clra", get_out(0), 8'h00);
      exec(1, 0, 'hFF);
      exec(2, 0, 0);
      exec(3, 0, 0);
      exec(1, 1, 'h33);
      exec(4, 0, 1);
      exec(4, 0, 0);
      rand_run(60);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
